// File: rtl/match_run_detector.sv
// match_run_detector
//   Compares two WIDTH-bit operands on every enabled cycle under a selectable
//   compare mode, counts consecutive matches and raises a registered detect
//   level once the run reaches a programmable threshold. It also produces a
//   one-cycle pulse on each new detection and keeps a saturating count of
//   detections.
//
// Ports
//   clk       system clock, rising edge
//   reset_n   synchronous active-low reset
//   en        sample enable; when low, all state holds
//   clr       synchronous run clear; takes priority over en, keeps hit_cnt
//   mode      00 A==B, 01 A!=B, 10 A>B (unsigned), 11 (A&mask)==(B&mask)
//   A, B      operands
//   mask      bit mask, used only in mode 11
//   thresh    required run length; 0 is treated as 1
//   det       level detect (registered)
//   det_pulse one-cycle pulse on entry to DETECTED
//   run_cnt   current consecutive-match count, saturating
//   hit_cnt   number of DETECTED entries, saturating
module match_run_detector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int HIT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] mask,
    input  logic [CNT_W-1:0] thresh,
    output logic             det,
    output logic             det_pulse,
    output logic [CNT_W-1:0] run_cnt,
    output logic [HIT_W-1:0] hit_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'b001,
        COUNTING = 3'b010,
        DETECTED = 3'b100
    } state_t;

    state_t state;

    logic             match;
    logic [CNT_W-1:0] t_eff;
    logic [CNT_W-1:0] nrun;

    always_comb begin
        match = 1'b0;
        unique case (mode)
            2'b00: match = (A == B);
            2'b01: match = (A != B);
            2'b10: match = (A > B);
            2'b11: match = ((A & mask) == (B & mask));
            default: match = 1'b0;
        endcase
    end

    assign t_eff = (thresh == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : thresh;

    // run length after this sample; saturates at all-ones
    always_comb begin
        nrun = '0;
        if (match)
            nrun = (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            run_cnt   <= '0;
            hit_cnt   <= '0;
            det       <= 1'b0;
            det_pulse <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            run_cnt   <= '0;
            det       <= 1'b0;
            det_pulse <= 1'b0;
        end else if (en) begin
            det_pulse <= 1'b0;
            run_cnt   <= nrun;
            case (state)
                IDLE, COUNTING: begin
                    if (!match) begin
                        state <= IDLE;
                        det   <= 1'b0;
                    end else if (nrun >= t_eff) begin
                        state     <= DETECTED;
                        det       <= 1'b1;
                        det_pulse <= 1'b1;
                        if (hit_cnt != '1)
                            hit_cnt <= hit_cnt + 1'b1;
                    end else begin
                        state <= COUNTING;
                        det   <= 1'b0;
                    end
                end
                // once detected, only a mismatch leaves; thresh is ignored here
                DETECTED: begin
                    if (match) begin
                        state <= DETECTED;
                        det   <= 1'b1;
                    end else begin
                        state <= IDLE;
                        det   <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    run_cnt <= '0;
                    det     <= 1'b0;
                end
            endcase
        end else begin
            det_pulse <= 1'b0;
        end
    end

endmodule

// File: doc/match_run_detector.md
Name: match_run_detector

Overview:
- Parametrised successor to the single-bit consecutive-equality detector in the ASM block set.
- Compares two WIDTH-bit operands each enabled cycle under a selectable compare mode and counts consecutive matches.
- Asserts a registered detect flag once the run reaches a runtime-programmable threshold, plus a one-cycle crossing pulse and a saturating detection-event counter.
- Sits between the operand sources and the control/status logic that consumes match events.

Parameters:
- WIDTH, 8, operand width in bits (>=1).
- CNT_W, 4, width of the run counter and threshold (>=2).
- HIT_W, 8, width of the detection-event counter (>=1).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
- en  input  1  sample enable; when 0, all state holds.
- clr  input  1  synchronous run clear; priority over en.
- mode  input  2  compare mode: 00 A==B, 01 A!=B, 10 A>B unsigned, 11 (A&mask)==(B&mask).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- mask  input  WIDTH  bit mask, used only in mode 11.
- thresh  input  CNT_W  required run length; 0 is treated as 1.
- det  output  1  level detect, registered.
- det_pulse  output  1  one-cycle pulse on entry to DETECTED.
- run_cnt  output  CNT_W  current consecutive-match count, saturating.
- hit_cnt  output  HIT_W  number of DETECTED entries, saturating.

Behaviour:
- Priority per rising clk: reset_n==0 > clr==1 > en==1 > hold.
- Reset (reset_n==0): state=IDLE, run_cnt=0, hit_cnt=0, det=0, det_pulse=0.
- clr==1 (reset_n==1): state=IDLE, run_cnt=0, det=0, det_pulse=0; hit_cnt holds.
- en==0 (no reset, no clr): state, run_cnt, det and hit_cnt hold; det_pulse=0.
- match is combinational from the current A, B, mask and mode. mode and mask are live each cycle, not latched.
- Effective threshold: T = (thresh==0) ? 1 : thresh. thresh is live each cycle.
- Enabled cycle, next run value: nrun = match ? (run_cnt==all-ones ? run_cnt : run_cnt+1) : 0. run_cnt <= nrun.
- State machine, one-hot, 3 states: IDLE=001, COUNTING=010, DETECTED=100. Transitions on enabled cycles only:
  - IDLE: !match -> IDLE. match && nrun>=T -> DETECTED. match && nrun<T -> COUNTING.
  - COUNTING: !match -> IDLE. match && nrun>=T -> DETECTED. Otherwise -> COUNTING.
  - DETECTED: match -> DETECTED, independent of thresh changes. !match -> IDLE.
  - Illegal encoding -> IDLE, with run_cnt=0 and det=0.
- Outputs:
  - det is registered and equals 1 exactly when the next state is DETECTED.
  - det_pulse=1 for one cycle on IDLE/COUNTING->DETECTED.
  - hit_cnt increments on each det_pulse and saturates at 2^HIT_W-1.
- Latency: det rises on the rising edge that samples the T-th consecutive enabled match. No combinational path from inputs to outputs.
- Gaps: cycles with en==0 do not break a run; the run continues from the next enabled cycle.
- run_cnt saturation does not affect det; det stays 1 while matches continue.
- Raising thresh above run_cnt while in DETECTED does not deassert det. Lowering thresh while in COUNTING takes effect on the next enabled match.
- Reset or clr mid-run discards the run. A new detection requires T fresh matches.

Test Plan:
- Reset, then mode=00, thresh=4, en=1, A=B=8'h5A for 6 cycles -> det=0 after edges 1–3; det=1 and det_pulse=1 after edge 4; det=1, det_pulse=0 after edges 5–6; hit_cnt=1; run_cnt=6.
- mode=00, thresh=4, 3 matches then A=8'h01, B=8'h02, then 4 matches -> run_cnt 1,2,3,0,1,2,3,4; single det_pulse on the final edge; hit_cnt=1.
- thresh=3, match pattern with en=0 for 2 cycles between matches 2 and 3 -> run_cnt holds at 2 during the gap; det rises on the 3rd enabled match.
- mode=11, mask=8'hF0, A=8'h3C, B=8'h35 -> match; mode=10 with A=8'h80, B=8'h7F -> match (unsigned); same operands with mode=00 -> no match.
- thresh=0, single match -> det=1 and det_pulse on the first edge. With CNT_W=4, 20 matches -> run_cnt saturates at 15 and det stays 1.
- Mid-run, assert clr with en=1, match -> run_cnt=0, det=0, hit_cnt unchanged. Then reset_n=0 for one edge -> hit_cnt=0, state IDLE.
